// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, bin operand handshake;
// out_valid/out_ready + diff, bout, digit_err result handshake.
// Optional macro BCD_SUB_SIGNMAG_EN: negative results are returned as magnitude (bout = sign).
module bcd_sub_serial #(
  parameter int DIGITS = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                digit_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_SUB_SIGNMAG_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_diff;
  logic [IW-1:0]   r_idx;
  logic            r_borrow;
  logic            r_bout;
  logic            r_err;

  logic [3:0]      w_ad;
  logic [3:0]      w_bd;
  logic [4:0]      w_t;
  logic [3:0]      w_d;
  logic            w_bo;
  logic            w_bad;
  logic            w_last;
  logic [W+3:0]    w_cat;

  // Operands and result are shift registers: the active digit is
  // always at the bottom, the new result digit enters at the top.
  assign w_cat  = {w_d, r_diff};
  assign w_last = (r_idx == IW'(DIGITS - 1));

  always_comb begin
    w_ad = r_a[3:0];
    w_bd = r_b[3:0];
`ifdef BCD_SUB_SIGNMAG_EN
    if (r_state == S_NEG) begin
      w_ad = 4'd0;
      w_bd = r_diff[3:0];
    end
`endif
    // 5 bits cover the full range -16..15 of raw nibble arithmetic.
    w_t   = {1'b0, w_ad} - {1'b0, w_bd} - {4'd0, r_borrow};
    w_bo  = w_t[4];
    w_d   = w_t[3:0] + (w_bo ? 4'd10 : 4'd0);
    w_bad = (w_ad > 4'd9) || (w_bd > 4'd9);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = S_RUN;
      S_RUN: begin
        if (w_last) begin
`ifdef BCD_SUB_SIGNMAG_EN
          w_next = w_bo ? S_NEG : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGNMAG_EN
      S_NEG: if (w_last) w_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
            r_err    <= 1'b0;
          end
        end
        S_RUN: begin
          r_a    <= r_a >> 4;
          r_b    <= r_b >> 4;
          r_diff <= w_cat[W+3:4];
          r_err  <= r_err | w_bad;
          if (w_last) begin
            r_idx    <= '0;
            r_bout   <= w_bo;
            // Negation pass starts with no borrow.
            r_borrow <= 1'b0;
          end else begin
            r_idx    <= r_idx + IW'(1);
            r_borrow <= w_bo;
          end
        end
`ifdef BCD_SUB_SIGNMAG_EN
        S_NEG: begin
          r_diff <= w_cat[W+3:4];
          if (w_last) begin
            r_idx    <= '0;
            r_borrow <= 1'b0;
          end else begin
            r_idx    <= r_idx + IW'(1);
            r_borrow <= w_bo;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign digit_err = r_err;

endmodule
